// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the dual-issue pipeline: arbitrates MDU and dcache stalls and runs a stall watchdog.
// Optional STALL_PERF_CNT_EN adds per-source stall-cycle counters.
module pipeline_stall_ctrl #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ex_mdu_req,
   input  logic       mdu_done,
   input  logic       dcache_stall_req,
   input  logic       MEM_br,
   input  logic       WB_flush_csr,
   output logic       stall_ex,
   output logic       stall_dcache,
   output logic       stall_ex_buf,
   output logic       stall_dcache_buf,
   output logic       stall_fe,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       flush_ex_mem,
   output logic       mdu_cancel,
   output logic       stall_timeout,
   output logic [1:0] ctrl_state
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] perf_ex_stall_cyc,
   output logic [31:0] perf_dc_stall_cyc
`endif
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_EX_WAIT = 2'd1,
      ST_DC_WAIT = 2'd2,
      ST_DC_EX   = 2'd3
   } state_t;

   state_t           state_q;
   logic             done_seen_q;
   logic             stall_ex_buf_q;
   logic             stall_dcache_buf_q;
   logic             stall_timeout_q;
   logic             timeout_d;
   logic [CNT_W-1:0] wd_cnt_q;
   logic [CNT_W-1:0] wd_cnt_d;
   logic             ex_pend;
   logic             flush_any;

   // Stall/cancel strobes are gated by rstn so a stall drops the moment reset asserts.
   assign ex_pend      = ex_mdu_req & ~mdu_done & ~done_seen_q;
   assign stall_ex     = rstn & ex_pend & ~WB_flush_csr;
   assign stall_dcache = rstn & dcache_stall_req;
   assign stall_fe     = stall_ex | stall_dcache;
   assign mdu_cancel   = rstn & WB_flush_csr &
                         (ex_mdu_req | (state_q == ST_EX_WAIT) | (state_q == ST_DC_EX));
   assign flush_any    = WB_flush_csr | MEM_br;
   assign flush_if_id  = flush_any;
   assign flush_id_ex  = flush_any;
   assign flush_ex_mem = flush_any;

   assign stall_ex_buf     = stall_ex_buf_q;
   assign stall_dcache_buf = stall_dcache_buf_q;
   assign stall_timeout    = stall_timeout_q;
   assign ctrl_state       = state_q;

   // Hazard FSM plus the flag remembering an MDU result that landed under a dcache stall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_RUN;
         done_seen_q <= 1'b0;
      end else if (WB_flush_csr) begin
         state_q     <= dcache_stall_req ? ST_DC_WAIT : ST_RUN;
         done_seen_q <= 1'b0;
      end else begin
         if (mdu_done && stall_dcache) begin
            done_seen_q <= 1'b1;
         end else if (!stall_ex && !stall_dcache) begin
            done_seen_q <= 1'b0;
         end else begin
            done_seen_q <= done_seen_q;
         end
         case (state_q)
            ST_RUN: begin
               if (dcache_stall_req) begin
                  state_q <= ex_pend ? ST_DC_EX : ST_DC_WAIT;
               end else if (ex_pend) begin
                  state_q <= ST_EX_WAIT;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_EX_WAIT: begin
               if (dcache_stall_req) begin
                  state_q <= ex_pend ? ST_DC_EX : ST_DC_WAIT;
               end else if (mdu_done) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_EX_WAIT;
               end
            end
            ST_DC_WAIT, ST_DC_EX: begin
               if (!dcache_stall_req) begin
                  state_q <= ex_pend ? ST_EX_WAIT : ST_RUN;
               end else begin
                  state_q <= ex_pend ? ST_DC_EX : ST_DC_WAIT;
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   // Watchdog next count: saturating while stalled, cleared whenever the pipe moves.
   always_comb begin
      wd_cnt_d  = {CNT_W{1'b0}};
      timeout_d = stall_timeout_q;
      if (stall_fe) begin
         if (wd_cnt_q == {CNT_W{1'b1}}) begin
            wd_cnt_d = wd_cnt_q;
         end else begin
            wd_cnt_d = wd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
         end else begin
            timeout_d = stall_timeout_q;
         end
      end else begin
         wd_cnt_d  = {CNT_W{1'b0}};
         timeout_d = stall_timeout_q;
      end
   end

   // Delayed stall copies and watchdog state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_ex_buf_q     <= 1'b0;
         stall_dcache_buf_q <= 1'b0;
         wd_cnt_q           <= {CNT_W{1'b0}};
         stall_timeout_q    <= 1'b0;
      end else begin
         stall_ex_buf_q     <= stall_ex;
         stall_dcache_buf_q <= stall_dcache;
         wd_cnt_q           <= wd_cnt_d;
         stall_timeout_q    <= timeout_d;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_ex_q;
   logic [31:0] perf_dc_q;

   // Free-running stall-cycle counters; both advance when both sources stall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_ex_q <= 32'd0;
         perf_dc_q <= 32'd0;
      end else begin
         perf_ex_q <= stall_ex ? perf_ex_q + 32'd1 : perf_ex_q;
         perf_dc_q <= stall_dcache ? perf_dc_q + 32'd1 : perf_dc_q;
      end
   end

   assign perf_ex_stall_cyc = perf_ex_q;
   assign perf_dc_stall_cyc = perf_dc_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed table-driven bench for pipeline_stall_ctrl with hand-written reset and watchdog sequences.
module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ex_mdu_req = 1'b0;
   logic       mdu_done = 1'b0;
   logic       dcache_stall_req = 1'b0;
   logic       MEM_br = 1'b0;
   logic       WB_flush_csr = 1'b0;
   logic       stall_ex, stall_dcache, stall_ex_buf, stall_dcache_buf, stall_fe;
   logic       flush_if_id, flush_id_ex, flush_ex_mem, mdu_cancel, stall_timeout;
   logic [1:0] ctrl_state;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_ex_stall_cyc, perf_dc_stall_cyc;
`endif

   int checks = 0;
   int failures = 0;

   pipeline_stall_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .rstn(rstn), .ex_mdu_req(ex_mdu_req), .mdu_done(mdu_done),
      .dcache_stall_req(dcache_stall_req), .MEM_br(MEM_br), .WB_flush_csr(WB_flush_csr),
      .stall_ex(stall_ex), .stall_dcache(stall_dcache), .stall_ex_buf(stall_ex_buf),
      .stall_dcache_buf(stall_dcache_buf), .stall_fe(stall_fe), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .mdu_cancel(mdu_cancel),
      .stall_timeout(stall_timeout), .ctrl_state(ctrl_state)
`ifdef STALL_PERF_CNT_EN
      , .perf_ex_stall_cyc(perf_ex_stall_cyc), .perf_dc_stall_cyc(perf_dc_stall_cyc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n, ex, done, dc, br, fl;
      logic       sx, sd, bx, bd, cn, to;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst_n, ex, done, dc, br, fl,
                      input logic sx, sd, bx, bd, cn, input logic [1:0] st, input logic to);
      vec_t v;
      v.rst_n = rst_n; v.ex = ex; v.done = done; v.dc = dc; v.br = br; v.fl = fl;
      v.sx = sx; v.sd = sd; v.bx = bx; v.bd = bd; v.cn = cn; v.st = st; v.to = to;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, ex, done, dc, br, fl);
      @(negedge clk);
      rstn = r; ex_mdu_req = ex; mdu_done = done; dcache_stall_req = dc;
      MEM_br = br; WB_flush_csr = fl;
      #1;
   endtask

   initial begin
      //   rst ex dn dc br fl   sx sd bx bd cn  st    to
      add(0, 1, 1, 1, 1, 1,   0, 0, 0, 0, 0, 2'd0, 0);  // reset, inputs high
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      // MDU only, six cycles, done on the sixth
      add(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1, 0);
      add(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 2'd1, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      // flush in EX_WAIT
      add(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 0, 0, 0, 1,   0, 0, 1, 0, 1, 2'd1, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      // flush in EX_WAIT with dcache stall outstanding
      add(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 0, 1, 0, 1,   0, 1, 1, 0, 1, 2'd1, 0);
      add(1, 0, 0, 1, 0, 0,   0, 1, 0, 1, 0, 2'd2, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2'd2, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      // MEM_br during MDU stall
      add(1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 2'd1, 0);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      // clean reset, then overlap scenario (8 consecutive stalled cycles trip the watchdog)
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd0, 0);
      add(1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 1, 0, 0,   1, 1, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 1, 0, 0,   1, 1, 1, 1, 0, 2'd3, 0);
      add(1, 1, 1, 1, 0, 0,   0, 1, 1, 1, 0, 2'd3, 0);
      add(1, 1, 0, 1, 0, 0,   0, 1, 0, 1, 0, 2'd2, 0);
      add(1, 1, 0, 1, 0, 0,   0, 1, 0, 1, 0, 2'd2, 0);
      add(1, 1, 0, 1, 0, 0,   0, 1, 0, 1, 0, 2'd2, 0);
      add(1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2'd2, 1);
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         v = tbl[i];
         drive(v.rst_n, v.ex, v.done, v.dc, v.br, v.fl);
         chk($sformatf("row%0d stall_ex", i), {31'd0, stall_ex}, {31'd0, v.sx});
         chk($sformatf("row%0d stall_dcache", i), {31'd0, stall_dcache}, {31'd0, v.sd});
         chk($sformatf("row%0d stall_fe", i), {31'd0, stall_fe}, {31'd0, v.sx | v.sd});
         chk($sformatf("row%0d stall_ex_buf", i), {31'd0, stall_ex_buf}, {31'd0, v.bx});
         chk($sformatf("row%0d stall_dcache_buf", i), {31'd0, stall_dcache_buf}, {31'd0, v.bd});
         chk($sformatf("row%0d mdu_cancel", i), {31'd0, mdu_cancel}, {31'd0, v.cn});
         chk($sformatf("row%0d ctrl_state", i), {30'd0, ctrl_state}, {30'd0, v.st});
         chk($sformatf("row%0d stall_timeout", i), {31'd0, stall_timeout}, {31'd0, v.to});
         if (v.rst_n) begin
            chk($sformatf("row%0d flushes", i), {29'd0, flush_if_id, flush_id_ex, flush_ex_mem},
                {29'd0, {3{v.fl | v.br}}});
         end else begin
            chk($sformatf("row%0d reset_stall_fe", i), {31'd0, stall_fe}, 32'd0);
         end
      end
`ifdef STALL_PERF_CNT_EN
      chk("perf_dc_stall_cyc", perf_dc_stall_cyc, 32'd6);
      chk("perf_ex_stall_cyc", perf_ex_stall_cyc, 32'd4);
`endif

      // reset in the middle of a stall, with done_seen set
      drive(1, 1, 0, 1, 0, 0);
      chk("mid_pre stall_fe", {31'd0, stall_fe}, 32'd1);
      drive(1, 1, 1, 1, 0, 0);
      chk("mid_done stall_ex", {31'd0, stall_ex}, 32'd0);
      drive(0, 1, 0, 1, 0, 0);
      chk("mid_rst stall_ex", {31'd0, stall_ex}, 32'd0);
      chk("mid_rst stall_dcache", {31'd0, stall_dcache}, 32'd0);
      chk("mid_rst stall_timeout", {31'd0, stall_timeout}, 32'd0);
      chk("mid_rst state", {30'd0, ctrl_state}, 32'd0);
      drive(1, 1, 0, 0, 0, 0);
      chk("post_rst stall_ex_buf", {31'd0, stall_ex_buf}, 32'd0);
      chk("post_rst stall_dcache_buf", {31'd0, stall_dcache_buf}, 32'd0);
      chk("post_rst done_seen_clear", {31'd0, stall_ex}, 32'd1);
      drive(1, 0, 0, 0, 0, 0);

      // watchdog: eight stalled cycles, then sticky after the request drops
      for (int c = 1; c <= 8; c++) begin
         drive(1, 0, 0, 1, 0, 0);
         chk($sformatf("wd_cyc%0d stall_timeout", c), {31'd0, stall_timeout}, 32'd0);
      end
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 0, 0, 0, 0);
         chk($sformatf("wd_after%0d stall_timeout", c), {31'd0, stall_timeout}, 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
